// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: instruction-trace capture for the schoolMIPS core.
// Stores {pc, instr, cycle stamp} per retired instruction in a circular buffer,
// with a PC-match trigger, a post-trigger window and a cycle-limit watchdog.
// Optional feature macro: SM_TRACE_CYCLE_EN (store per-entry cycle stamps).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; captures ignored until armed
//   RUN   | capturing, PC-match trigger live
//   POST  | trigger seen, capturing the remaining post-trigger entries
//   DONE  | capture finished (trigger window or watchdog); buffer frozen
module sm_trace_buffer #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap_en,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               arm,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [AW-1:0]      post_cnt,
    input  logic [CNT_W-1:0]   timeout,
    input  logic [AW-1:0]      rd_addr,
    output logic [PC_W-1:0]    rd_pc,
    output logic [INSTR_W-1:0] rd_instr,
    output logic [CNT_W-1:0]   rd_cycle,
    output logic [1:0]         state,
    output logic [AW:0]        count,
    output logic               timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_POST = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [AW-1:0]      remain_q, remain_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
    logic [INSTR_W-1:0] rd_instr_q, rd_instr_d;

    logic [PC_W+INSTR_W-1:0] mem_q [DEPTH];

    logic               capture;
    logic               trig_hit;
    logic [CNT_W-1:0]   cycle_inc;
    logic [AW-1:0]      oldest;
    logic [AW-1:0]      phys;
    logic               rd_valid;

    // A capture happens only while armed; a simultaneous arm drops it.
    always_comb begin
        capture   = cap_en && !arm && ((state_q == ST_RUN) || (state_q == ST_POST));
        trig_hit  = trig_en && (pc == trig_pc);
        cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
    end

    // Next-state logic for the capture FSM, pointers, counters and watchdog.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        cycle_d        = cycle_q;
        remain_d       = remain_q;
        timeout_flag_d = timeout_flag_q;
        if (arm) begin
            state_d        = ST_RUN;
            wr_ptr_d       = '0;
            count_d        = '0;
            cycle_d        = '0;
            timeout_flag_d = 1'b0;
        end else if (capture) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = (count_q == DEPTH_C) ? count_q : count_q + (AW+1)'(1);
            cycle_d  = cycle_inc;
            if (state_q == ST_RUN) begin
                if (trig_hit) begin
                    if (post_cnt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        remain_d = post_cnt;
                        state_d  = ST_POST;
                    end
                end
            end else begin
                remain_d = remain_q - AW'(1);
                if (remain_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            // Watchdog overrides the trigger outcome on the same capture.
            if ((timeout != '0) && (cycle_inc == timeout)) begin
                timeout_flag_d = 1'b1;
                state_d        = ST_DONE;
            end
        end
    end

    // Readout address mapping: index 0 is the oldest surviving entry.
    always_comb begin
        oldest     = (count_q < DEPTH_C) ? '0 : wr_ptr_q;
        phys       = oldest + rd_addr;
        rd_valid   = ({1'b0, rd_addr} < count_q);
        rd_pc_d    = rd_valid ? mem_q[phys][PC_W+INSTR_W-1:INSTR_W] : '0;
        rd_instr_d = rd_valid ? mem_q[phys][INSTR_W-1:0] : '0;
    end

    // FSM and control registers, plus registered readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            cycle_q        <= '0;
            remain_q       <= '0;
            timeout_flag_q <= 1'b0;
            rd_pc_q        <= '0;
            rd_instr_q     <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            cycle_q        <= cycle_d;
            remain_q       <= remain_d;
            timeout_flag_q <= timeout_flag_d;
            rd_pc_q        <= rd_pc_d;
            rd_instr_q     <= rd_instr_d;
        end
    end

    // Trace storage; reads above see the pre-write contents of a slot.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= {pc, instr};
        end
    end

`ifdef SM_TRACE_CYCLE_EN
    logic [CNT_W-1:0] mem_cyc_q [DEPTH];
    logic [CNT_W-1:0] rd_cycle_q, rd_cycle_d;

    // Cycle-stamp readout follows the same mapping as pc/instr.
    always_comb begin
        rd_cycle_d = rd_valid ? mem_cyc_q[phys] : '0;
    end

    // Stamp storage: the counter value before this capture's increment.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_cyc_q[wr_ptr_q] <= cycle_q;
        end
    end

    // Registered stamp readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cycle_q <= '0;
        end else begin
            rd_cycle_q <= rd_cycle_d;
        end
    end

    assign rd_cycle = rd_cycle_q;
`else
    assign rd_cycle = '0;
`endif

    assign rd_pc        = rd_pc_q;
    assign rd_instr     = rd_instr_q;
    assign state        = state_q;
    assign count        = count_q;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Scoreboard bench for sm_trace_buffer: the stimulus process drives one cycle
// at a time, updates a queue-based trace model and pushes the expected status
// and readout; a monitor pops and compares one cycle later.
module tb_sm_trace_buffer;

    localparam int DEPTH = 16;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_POST = 2, ST_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cap_en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [3:0]  post_cnt = '0;
    logic [15:0] timeout = '0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [15:0] rd_cycle;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        timeout_flag;

    sm_trace_buffer dut (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .pc(pc), .instr(instr),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
        .timeout(timeout), .rd_addr(rd_addr), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_cycle(rd_cycle), .state(state), .count(count), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] cyc;
    } ent_t;

    typedef struct {
        int          due;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic        flag;
        logic [31:0] rpc;
        logic [31:0] rinstr;
        logic [15:0] rcyc;
    } exp_t;

    ent_t tr[$];
    exp_t sb[$];
    int   m_state = ST_IDLE;
    int   m_cycle = 0;
    int   m_remain = 0;
    bit   m_flag = 1'b0;

    logic        cfg_trig_en = 1'b0;
    logic [31:0] cfg_trig_pc = '0;
    logic [3:0]  cfg_post_cnt = '0;
    logic [15:0] cfg_timeout = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    task automatic model_reset();
        tr.delete();
        m_state  = ST_IDLE;
        m_cycle  = 0;
        m_remain = 0;
        m_flag   = 1'b0;
    endtask

    // One clock of stimulus; expectation is due after the next active edge.
    task automatic step(input bit a, input bit ce, input logic [31:0] p, input logic [3:0] ra);
        exp_t e;
        ent_t n;
        logic [31:0] ins;
        @(posedge clk);
        #1;
        ins      = $urandom;
        arm      = a;
        cap_en   = ce;
        pc       = p;
        instr    = ins;
        rd_addr  = ra;
        trig_en  = cfg_trig_en;
        trig_pc  = cfg_trig_pc;
        post_cnt = cfg_post_cnt;
        timeout  = cfg_timeout;

        e.due = cyc + 1;
        if (int'(ra) < tr.size()) begin
            e.rpc    = tr[ra].pc;
            e.rinstr = tr[ra].instr;
`ifdef SM_TRACE_CYCLE_EN
            e.rcyc   = tr[ra].cyc;
`else
            e.rcyc   = '0;
`endif
        end else begin
            e.rpc    = '0;
            e.rinstr = '0;
            e.rcyc   = '0;
        end

        if (a) begin
            tr.delete();
            m_cycle = 0;
            m_flag  = 1'b0;
            m_state = ST_RUN;
        end else if (ce && (m_state == ST_RUN || m_state == ST_POST)) begin
            n.pc    = p;
            n.instr = ins;
            n.cyc   = 16'(m_cycle);
            tr.push_back(n);
            if (tr.size() > DEPTH) void'(tr.pop_front());
            if (m_cycle < 65535) m_cycle++;
            if (m_state == ST_RUN) begin
                if (cfg_trig_en && p == cfg_trig_pc) begin
                    if (cfg_post_cnt == 0) m_state = ST_DONE;
                    else begin
                        m_remain = int'(cfg_post_cnt);
                        m_state  = ST_POST;
                    end
                end
            end else begin
                m_remain--;
                if (m_remain == 0) m_state = ST_DONE;
            end
            if (cfg_timeout != 0 && m_cycle == int'(cfg_timeout)) begin
                m_flag  = 1'b1;
                m_state = ST_DONE;
            end
        end

        e.st   = 2'(m_state);
        e.cnt  = 5'(tr.size());
        e.flag = m_flag;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 64'(state), 64'(0));
        chk({tag, "_count"}, 64'(count), 64'(0));
        chk({tag, "_flag"},  64'(timeout_flag), 64'(0));
        chk({tag, "_rd_pc"}, 64'(rd_pc), 64'(0));
        chk({tag, "_rd_instr"}, 64'(rd_instr), 64'(0));
        chk({tag, "_rd_cycle"}, 64'(rd_cycle), 64'(0));
    endtask

    // Idle one cycle so pending expectations drain, then reset asynchronously.
    task automatic reset_mid(input string tag);
        @(posedge clk);
        #1;
        arm    = 1'b0;
        cap_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare each expectation on the falling edge it falls due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("state",    64'(state),        64'(e.st));
                chk("count",    64'(count),        64'(e.cnt));
                chk("tflag",    64'(timeout_flag), 64'(e.flag));
                chk("rd_pc",    64'(rd_pc),        64'(e.rpc));
                chk("rd_instr", 64'(rd_instr),     64'(e.rinstr));
                chk("rd_cycle", 64'(rd_cycle),     64'(e.rcyc));
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture and readout, including an index past count.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 32'(i), 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 4'(i));

        // Wraparound: oldest entry follows the write pointer once full.
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 32'(i), 4'(i));
        step(0, 0, 0, 0);
        step(0, 0, 0, 15);
        step(0, 0, 0, 7);

        // PC trigger with a post-trigger window of 3.
        cfg_trig_en = 1'b1; cfg_trig_pc = 32'd10; cfg_post_cnt = 4'd3;
        step(1, 0, 0, 0);
        for (int i = 0; i <= 30; i++) step(0, 1, 32'(i), 4'(i % 16));
        step(0, 0, 0, 13);
        step(0, 0, 0, 14);
        step(0, 0, 0, 0);

        // Watchdog stops capture after the 8th entry.
        cfg_trig_en = 1'b0; cfg_post_cnt = 4'd0; cfg_timeout = 16'd8;
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 32'(100 + i), 4'(i));
        step(0, 0, 0, 7);
        step(0, 0, 0, 8);

        // Trigger and watchdog on the same capture.
        cfg_trig_en = 1'b1; cfg_trig_pc = 32'd3; cfg_post_cnt = 4'd2; cfg_timeout = 16'd4;
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 32'(i), 4'(i));

        // Reset in the middle of a run.
        cfg_trig_en = 1'b0; cfg_timeout = 16'd0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'(i), 0);
        reset_mid("rst_mid");
        step(0, 1, 32'd7, 0);
        step(0, 0, 0, 0);

        // arm beats cap_en; arm during POST restarts cleanly.
        step(1, 1, 32'd99, 0);
        step(0, 0, 0, 0);
        cfg_trig_en = 1'b1; cfg_trig_pc = 32'd2; cfg_post_cnt = 4'd5;
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'(i), 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit a;
            a = ($urandom_range(0, 39) == 0);
            if (a || $urandom_range(0, 49) == 0) begin
                cfg_trig_en  = 1'($urandom_range(0, 1));
                cfg_trig_pc  = 32'($urandom_range(0, 15));
                cfg_post_cnt = 4'($urandom_range(0, 15));
                cfg_timeout  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            end
            step(a, ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #1;
        arm    = 1'b0;
        cap_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
